// File: rtl/uart_defs.sv
// ============================================================================
// uart_defs : shared UART state encodings and 9600-baud timebase constants
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    // 100 MHz / 9600 baud = 10417 clocks per bit
    localparam int unsigned c_baud_cnt_max = 10416;
    localparam int unsigned c_half_cnt     = 5208;
    localparam int unsigned c_baud_cnt_w   = 15;

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// uart_baud_tick : bit-period counter with mid-bit and end-of-bit strobes
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_baud_tick
    import uart_defs::*;
#(
    parameter int unsigned BAUD_CNT_MAX = c_baud_cnt_max,
    parameter int unsigned HALF_CNT     = c_half_cnt
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic mid_tick,
    output logic end_tick
);

    localparam logic [c_baud_cnt_w-1:0] c_end = c_baud_cnt_w'(BAUD_CNT_MAX);
    localparam logic [c_baud_cnt_w-1:0] c_mid = c_baud_cnt_w'(HALF_CNT);

    logic [c_baud_cnt_w-1:0] r_baud_cnt;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            r_baud_cnt <= '0;
        end else if (enable) begin
            if (r_baud_cnt == c_end) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
        end
    end

    assign mid_tick = (r_baud_cnt == c_mid);
    assign end_tick = (r_baud_cnt == c_end);

endmodule

`default_nettype wire

// File: rtl/uart_recv.sv
// ============================================================================
// uart_recv : 8N1 LSB-first UART receiver with one-cycle valid/frame_err pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_recv
    import uart_defs::*;
#(
    parameter int unsigned BAUD_CNT_MAX = c_baud_cnt_max,
    parameter int unsigned HALF_CNT     = c_half_cnt
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       valid,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       busy
);

    uart_state_t r_state;
    uart_state_t w_state_next;

    logic       r_din_s1;
    logic       r_din_s2;
    logic       r_din_d;
    logic       w_fall;
    logic       w_mid_tick;
    logic       w_end_tick;
    logic       w_cnt_clear;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_frame_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_din_s1 <= 1'b1;
            r_din_s2 <= 1'b1;
            r_din_d  <= 1'b1;
        end else begin
            r_din_s1 <= din;
            r_din_s2 <= r_din_s1;
            r_din_d  <= r_din_s2;
        end
    end

    assign w_fall = r_din_d & ~r_din_s2;

    // Counter is zero whenever the FSM sits in or is about to enter IDLE,
    // so each frame starts counting from zero on the START entry edge.
    assign w_cnt_clear = (r_state == IDLE) || (w_state_next == IDLE);

    uart_baud_tick #(
        .BAUD_CNT_MAX (BAUD_CNT_MAX),
        .HALF_CNT     (HALF_CNT)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_cnt_clear),
        .enable   (1'b1),
        .mid_tick (w_mid_tick),
        .end_tick (w_end_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_fall) w_state_next = START;
            end
            START: begin
                if (w_mid_tick && r_din_s2) w_state_next = IDLE;
                else if (w_end_tick)        w_state_next = DATA;
            end
            DATA: begin
                if (w_end_tick && (r_bit_cnt == 3'd7)) w_state_next = STOP;
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is caught
                if (w_mid_tick) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                START: begin
                    if (w_end_tick) r_bit_cnt <= 3'd0;
                end
                DATA: begin
                    if (w_mid_tick) r_shift[r_bit_cnt] <= r_din_s2;
                    if (w_end_tick) r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                STOP: begin
                    if (w_mid_tick) begin
                        if (r_din_s2) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid     = r_valid;
    assign data      = r_data;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- UART receiver, 8N1, LSB first.
- Sits upstream of uart_send on the UART com-and-display path. It deserialises the line input and presents each byte as a one-cycle valid pulse with 8-bit data, which feeds the display, the matcher and uart_send's valid/data inputs.
- Same baud timebase as uart_send: 100 MHz clk, 9600 baud, 10417 clocks per bit.

Parameters:
- BAUD_CNT_MAX, 10416: last baud counter value; one bit period is BAUD_CNT_MAX+1 clocks.
- HALF_CNT, 5208: counter value at the bit centre, where the line is sampled; must equal BAUD_CNT_MAX/2.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous active-low reset; sampled on the rising edge of clk; 0 = reset.
- din  input  1  asynchronous serial line, idle high.
- valid  output  1  one-clk pulse; data holds a newly received byte.
- data  output  8  last received byte; held until the next good frame.
- frame_err  output  1  one-clk pulse; stop bit was sampled low.
- busy  output  1  high while state is not IDLE.

Behaviour:
- Input conditioning:
  - din passes through a 2-FF synchroniser (din_s1, din_s2), both reset to 1.
  - A third register, din_d, detects the falling edge: din_d=1 and din_s2=0.
  - All decisions use din_s2.
- Reset (rst=0 at a clk edge):
  - state=IDLE; baud_cnt=0; bit_cnt=0; shift register=0.
  - data=8'h00; valid=0; frame_err=0; busy=0; synchroniser registers=1.
- baud_cnt (15 bits):
  - Held at 0 in IDLE.
  - In other states it counts up by 1 per clk.
  - It wraps from BAUD_CNT_MAX to 0.
  - The end of a bit is baud_cnt==BAUD_CNT_MAX.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - A falling edge on din_s2 moves the FSM to START with baud_cnt=0.
- START:
  - At baud_cnt==HALF_CNT: if din_s2=1, treat it as a glitch and return to IDLE (no outputs).
  - Otherwise, at the end of the bit, go to DATA with bit_cnt=0.
- DATA:
  - At baud_cnt==HALF_CNT, sample din_s2 into shift[bit_cnt], so bit 0 (received first) lands in shift[0].
  - At the end of each bit, bit_cnt increments.
  - At the end of the bit with bit_cnt==7, go to STOP; bit_cnt wraps to 0.
- STOP:
  - At baud_cnt==HALF_CNT, sample the stop bit.
  - If it is 1: data<=shift; valid=1 on the next cycle only.
  - If it is 0: frame_err=1 for one cycle; data is unchanged; valid stays 0.
  - In both cases, go to IDLE on the same edge (half stop bit). This allows back-to-back frames with minimum stop length.
- Latency:
  - The valid pulse asserts about 9.5 bit periods after the start-bit falling edge at din_s2.
  - Add 2 clks for the synchroniser.
- valid and frame_err are mutually exclusive and never asserted in consecutive cycles for the same frame.
- A falling edge during START, DATA or STOP is ignored; only mid-bit samples count.
- A line held low after a frame error does not retrigger. A new frame needs a 1->0 transition seen in IDLE.
- When rst falls mid-frame, the frame is aborted on that edge and no valid pulse is issued. After rst returns high, the receiver waits for a fresh falling edge.
- A continuous high line never produces valid.

Decomposition:
- Shared package/header (uart_defs), also used by uart_send:
  - state encodings IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11;
  - BAUD_CNT_MAX=10416;
  - HALF_CNT=5208.
- One natural sub-module: uart_baud_tick. It is the baud counter with clear/enable inputs and outputs mid_tick and end_tick; uart_send can reuse it later.
- The synchroniser stays inline.

Test Plan (bench sets BAUD_CNT_MAX=15, HALF_CNT=7 for speed; bit period is 16 clks):
- Reset and idle: hold rst=0 for 3 clks with din=1, then keep din=1 for 500 clks -> data=8'h00; valid, frame_err and busy stay 0 throughout.
- Single frame: send 8'hA5 (0,1,0,1,0,0,1,0,1,1 on the line) -> exactly one valid pulse; data=8'hA5; frame_err=0; busy drops the cycle after the STOP mid-sample.
- Back-to-back frames: send 8'h00 then 8'hFF with a one-bit stop and no idle gap -> two valid pulses with data 8'h00 then 8'hFF; no missed start bit.
- Glitch rejection: pulse din low for 4 clks, then keep it high -> FSM returns to IDLE; no valid; no frame_err; data unchanged.
- Framing error: send 8'h3C with the stop bit driven 0, then keep the line low for 40 clks -> one frame_err pulse; no valid; data retains its previous value; no retrigger until din goes high and then falls again.
- Reset mid-frame: assert rst=0 for 1 clk during data bit 4 of 8'h5A, then send 8'hC3 -> no valid for 8'h5A; one valid pulse with data=8'hC3.
